// File: rtl/hs_npu_inference_seq.sv
// hs_npu_inference_seq: sequencer FSM driving one NPU inference pass (flush, bias, weights, inputs, launch, drain).
// Optional watchdog with sticky error_o when HS_NPU_SEQ_WATCHDOG_EN is defined.
module hs_npu_inference_seq #(
  parameter int SIZE = 8,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] cfg_rows_i,
  input  logic                 cfg_relu_i,
  input  logic [CNT_WIDTH-1:0] cfg_shift_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 flush_input_fifos_o,
  output logic                 flush_weight_fifos_o,
  output logic                 flush_output_fifos_o,
  output logic                 bias_en_o,
  output logic                 weight_load_en_o,
  input  logic                 weight_hs_i,
  output logic                 enable_weights_o,
  output logic                 input_load_en_o,
  input  logic                 input_hs_i,
  output logic                 start_input_gatekeeper_o,
  output logic                 start_output_gatekeeper_o,
  output logic [CNT_WIDTH-1:0] enable_cycles_o,
  output logic                 relu_enable_o,
  output logic [CNT_WIDTH-1:0] shift_amount_o,
  input  logic                 out_valid_i,
  input  logic                 result_ready_i,
  output logic                 output_ready_o
`ifdef HS_NPU_SEQ_WATCHDOG_EN
  ,
  output logic                 error_o
`endif
);
  typedef enum logic [3:0] {IDLE, FLUSH, LOAD_W, SHIFT_W, LOAD_IN, LAUNCH, DRAIN, DONE, ABORT} state_t;
  state_t state, nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic accept, step, last, timeout;
  assign accept = state == IDLE && start_i && !abort_i;
  assign step = state == LOAD_W  ? weight_hs_i :
                state == SHIFT_W ? 1'b1 :
                state == LOAD_IN ? input_hs_i :
                state == DRAIN   ? out_valid_i && result_ready_i : 1'b0;
  assign last = cnt == ((state == LOAD_W || state == SHIFT_W) ? CNT_WIDTH'(SIZE - 1)
                                                              : enable_cycles_o - CNT_WIDTH'(1));
  assign output_ready_o = state == DRAIN && result_ready_i;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !accept ? IDLE : cfg_rows_i == '0 ? DONE : FLUSH;
      FLUSH:   nxt = LOAD_W;
      LOAD_W:  nxt = step && last ? SHIFT_W : LOAD_W;
      SHIFT_W: nxt = last ? LOAD_IN : SHIFT_W;
      LOAD_IN: nxt = step && last ? LAUNCH : LOAD_IN;
      LAUNCH:  nxt = DRAIN;
      DRAIN:   nxt = step && last ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
    if (state != IDLE && (abort_i || timeout)) nxt = ABORT;
  end
`ifdef HS_NPU_SEQ_WATCHDOG_EN
  logic [31:0] wd;
  assign timeout = (state == LOAD_W || state == LOAD_IN || state == DRAIN) && wd == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd <= '0;
      error_o <= 1'b0;
    end else begin
      wd <= nxt != state ? '0 : wd + 32'd1;
      error_o <= accept ? 1'b0 : timeout ? 1'b1 : error_o;
    end
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  // Outputs are decoded from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      flush_input_fifos_o <= 1'b0;
      flush_weight_fifos_o <= 1'b0;
      flush_output_fifos_o <= 1'b0;
      bias_en_o <= 1'b0;
      weight_load_en_o <= 1'b0;
      enable_weights_o <= 1'b0;
      input_load_en_o <= 1'b0;
      start_input_gatekeeper_o <= 1'b0;
      start_output_gatekeeper_o <= 1'b0;
      enable_cycles_o <= '0;
      relu_enable_o <= 1'b0;
      shift_amount_o <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + CNT_WIDTH'(step);
      busy_o <= nxt != IDLE;
      done_o <= nxt == DONE;
      flush_input_fifos_o <= nxt == FLUSH || nxt == ABORT;
      flush_weight_fifos_o <= nxt == FLUSH || nxt == ABORT;
      flush_output_fifos_o <= nxt == FLUSH || nxt == ABORT;
      bias_en_o <= nxt == FLUSH;
      weight_load_en_o <= nxt == LOAD_W;
      enable_weights_o <= nxt == SHIFT_W;
      input_load_en_o <= nxt == LOAD_IN;
      start_input_gatekeeper_o <= nxt == LAUNCH;
      start_output_gatekeeper_o <= nxt == LAUNCH;
      enable_cycles_o <= accept ? cfg_rows_i : enable_cycles_o;
      relu_enable_o <= accept ? cfg_relu_i : relu_enable_o;
      shift_amount_o <= accept ? cfg_shift_i : shift_amount_o;
    end
endmodule

// File: tb/tb_hs_npu_inference_seq.sv
// tb_hs_npu_inference_seq: randomized passes with a scoreboard of per-pass expectations checked by a monitor.
module tb_hs_npu_inference_seq;
  localparam int SIZE = 8;
  logic clk = 1'b0;
  logic rst;
  logic start_i = 0, abort_i = 0, cfg_relu_i = 0, weight_hs_i = 0, input_hs_i = 0, out_valid_i = 0, result_ready_i = 0;
  logic [31:0] cfg_rows_i = '0, cfg_shift_i = '0;
  logic busy_o, done_o, fi, fw, fo, bias_en_o, weight_load_en_o, enable_weights_o, input_load_en_o;
  logic sig, sog, relu_enable_o, output_ready_o;
  logic [31:0] enable_cycles_o, shift_amount_o;
  int checks = 0, errors = 0;
  logic [31:0] last_rows = '0;
  typedef struct {
    logic [31:0] rows;
    logic        relu;
    logic [31:0] shift;
    int          kind;
    int          abort_after;
  } exp_t;
  exp_t expq[$];
  always #5 clk = ~clk;
  hs_npu_inference_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .cfg_rows_i(cfg_rows_i), .cfg_relu_i(cfg_relu_i), .cfg_shift_i(cfg_shift_i),
    .busy_o(busy_o), .done_o(done_o),
    .flush_input_fifos_o(fi), .flush_weight_fifos_o(fw), .flush_output_fifos_o(fo),
    .bias_en_o(bias_en_o), .weight_load_en_o(weight_load_en_o), .weight_hs_i(weight_hs_i),
    .enable_weights_o(enable_weights_o), .input_load_en_o(input_load_en_o), .input_hs_i(input_hs_i),
    .start_input_gatekeeper_o(sig), .start_output_gatekeeper_o(sog),
    .enable_cycles_o(enable_cycles_o), .relu_enable_o(relu_enable_o), .shift_amount_o(shift_amount_o),
    .out_valid_i(out_valid_i), .result_ready_i(result_ready_i), .output_ready_o(output_ready_o)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Monitor: accumulates what one pass did and checks it against the scoreboard when busy_o falls.
  int n_busy = 0, n_done = 0, n_flush = 0, n_bias = 0, n_ew = 0, n_w = 0, n_i = 0, n_gk = 0, n_pop = 0;
  longint c_rows = 0, c_relu = 0, c_shift = 0;
  bit prev_busy = 0, in_drain = 0;
  exp_t m_e;
  initial forever begin
    @(negedge clk);
    if (!result_ready_i) chk("oready_without_ready", output_ready_o, 0);
    in_drain = in_drain && !done_o && !fi;
    if (in_drain) chk("oready_in_drain", output_ready_o, result_ready_i);
    if (busy_o) begin
      n_busy++;
      if (done_o) begin
        n_done++;
        c_rows = enable_cycles_o;
        c_relu = relu_enable_o;
        c_shift = shift_amount_o;
      end
      if (fi && fw && fo) n_flush++;
      if (bias_en_o) n_bias++;
      if (enable_weights_o) n_ew++;
      if (weight_hs_i && weight_load_en_o) n_w++;
      if (input_hs_i && input_load_en_o) n_i++;
      if (sig && sog) n_gk++;
      if (out_valid_i && output_ready_o) n_pop++;
      if (sog) in_drain = 1;
    end else if (prev_busy) begin
      if (expq.size() == 0) chk("unexpected_pass", 1, 0);
      else begin
        m_e = expq.pop_front();
        if (m_e.kind != 2) begin
          chk("done_pulses", n_done, m_e.kind == 0);
          chk("flush_cycles", n_flush, m_e.kind == 1 ? 2 : m_e.rows != 0);
          chk("bias_cycles", n_bias, m_e.rows != 0);
          chk("shift_w_cycles", n_ew, m_e.rows != 0 ? SIZE : 0);
          chk("weight_rows", n_w, m_e.rows != 0 ? SIZE : 0);
          chk("input_rows", n_i, m_e.kind == 1 ? m_e.abort_after : m_e.rows);
          chk("gatekeeper_pulses", n_gk, m_e.kind == 0 && m_e.rows != 0);
          chk("result_pops", n_pop, m_e.kind == 0 ? m_e.rows : 0);
          if (m_e.kind == 0) begin
            chk("enable_cycles", c_rows, m_e.rows);
            chk("relu_enable", c_relu, m_e.relu);
            chk("shift_amount", c_shift, m_e.shift);
          end
          if (m_e.rows == 0) chk("zero_rows_busy_cycles", n_busy, 1);
        end
      end
      {n_busy, n_done, n_flush, n_bias, n_ew, n_w, n_i, n_gk, n_pop} = '0;
      in_drain = 0;
    end
    prev_busy = busy_o;
  end
  task automatic issue_start(input exp_t e);
    @(posedge clk); #1;
    start_i = 1; cfg_rows_i = e.rows; cfg_relu_i = e.relu; cfg_shift_i = e.shift;
    @(posedge clk); #1;
    start_i = 0; cfg_rows_i = $urandom; cfg_relu_i = 1'($urandom); cfg_shift_i = $urandom;
    last_rows = e.rows;
  endtask
  task automatic idle_inputs();
    {weight_hs_i, input_hs_i, out_valid_i, result_ready_i, abort_i} = '0;
  endtask
  task automatic run_pass(input logic [31:0] rows, input int abort_after, input bit bp);
    exp_t e;
    int cyc = 0, n_in = 0, hold = 0;
    bit drain = 0, aborted = 0;
    e.rows = rows; e.relu = 1'($urandom); e.shift = $urandom_range(0, 31);
    e.kind = abort_after >= 0 ? 1 : 0; e.abort_after = abort_after;
    expq.push_back(e);
    issue_start(e);
    while (busy_o && cyc < 2000) begin
      weight_hs_i = 1'($urandom); input_hs_i = 1'($urandom);
      out_valid_i = 1'($urandom); result_ready_i = 1'($urandom); abort_i = 0;
      if (bp && drain && hold < 10) begin
        out_valid_i = 1; result_ready_i = 0; hold++;
      end
      if (abort_after >= 0 && !aborted && input_load_en_o && n_in == abort_after) begin
        abort_i = 1; input_hs_i = 0; aborted = 1;
      end
      if (input_load_en_o && input_hs_i) n_in++;
      if (sog) drain = 1;
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    chk("pass_within_budget", cyc < 2000, 1);
  endtask
  task automatic start_abort_idle();
    @(posedge clk); #1;
    start_i = 1; abort_i = 1; cfg_rows_i = 5;
    @(posedge clk); #1;
    start_i = 0; abort_i = 0;
    chk("start_abort_busy", busy_o, 0);
    @(posedge clk); #1;
    chk("start_abort_busy_later", busy_o, 0);
    chk("start_abort_no_latch", enable_cycles_o, last_rows);
  endtask
  task automatic reset_mid_shift();
    exp_t e;
    int cyc = 0;
    e.rows = 3; e.relu = 1; e.shift = 7; e.kind = 2; e.abort_after = -1;
    expq.push_back(e);
    issue_start(e);
    while (!enable_weights_o && cyc < 500) begin
      weight_hs_i = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    chk("reached_shift_w", cyc < 500, 1);
    #3 rst = 1;
    #1;
    chk("async_reset_outputs", {busy_o, done_o, fi, fw, fo, bias_en_o, weight_load_en_o, enable_weights_o,
                                input_load_en_o, sig, sog, relu_enable_o, output_ready_o}, 0);
    chk("async_reset_cfg", enable_cycles_o | shift_amount_o, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask
  initial begin
    int r;
    rst = 1;
    #12;
    chk("reset_outputs", {busy_o, done_o, fi, fw, fo, bias_en_o, weight_load_en_o, enable_weights_o,
                          input_load_en_o, sig, sog, relu_enable_o, output_ready_o}, 0);
    chk("reset_cfg", enable_cycles_o | shift_amount_o, 0);
    @(posedge clk); #1;
    rst = 0;
    run_pass(3, -1, 0);
    run_pass(0, -1, 0);
    run_pass(4, -1, 1);
    run_pass(4, 1, 0);
    run_pass(2, -1, 0);
    start_abort_idle();
    reset_mid_shift();
    run_pass(5, -1, 0);
    repeat (8) run_pass($urandom_range(1, 6), -1, 1'($urandom));
    repeat (3) begin
      r = $urandom_range(2, 6);
      run_pass(r, $urandom_range(0, r - 1), 0);
    end
    run_pass(0, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
